// File: rtl/seven_seg_scan_driver.sv
// Multiplexed seven-segment scan driver with double-buffered codes, blanking and blinking.
// Optional leading-zero suppression is enabled by defining SEVSEG_LZ_BLANK_EN.
module seven_seg_scan_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 100000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [5*NUM_DIGITS-1:0] codes,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [PW-1:0] presc;
  logic [IW-1:0] idx;
  logic [FW-1:0] fcnt;
  logic          phase;
  logic          pend_v;
  logic [NUM_DIGITS-1:0][4:0] pend_codes, act_codes;
  logic [NUM_DIGITS-1:0]      pend_blank, pend_blink, act_blank, act_blink;
  logic tick, wrap, dark;

  // Active-low segment pattern, bit order {g,f,e,d,c,b,a}
  function automatic logic [6:0] glyph(input logic [4:0] c);
    case (c)
      5'd0:  glyph = 7'h40;
      5'd1:  glyph = 7'h79;
      5'd2:  glyph = 7'h24;
      5'd3:  glyph = 7'h30;
      5'd4:  glyph = 7'h19;
      5'd5:  glyph = 7'h12;
      5'd6:  glyph = 7'h02;
      5'd7:  glyph = 7'h78;
      5'd8:  glyph = 7'h00;
      5'd9:  glyph = 7'h10;
      5'd14: glyph = 7'h06;
      5'd15: glyph = 7'h2F;
      5'd16: glyph = 7'h12;
      5'd17: glyph = 7'h63;
      5'd18: glyph = 7'h03;
      5'd19: glyph = 7'h0C;
      5'd20: glyph = 7'h47;
      5'd21: glyph = 7'h41;
      default: glyph = 7'h7F;
    endcase
  endfunction

  assign tick = (presc == PW'(SCAN_DIV - 1));
  assign wrap = tick && (idx == IW'(NUM_DIGITS - 1));

`ifdef SEVSEG_LZ_BLANK_EN
  logic [NUM_DIGITS-1:0] lz;

  function automatic logic zero_like(input logic [4:0] c);
    zero_like = (c == 5'd0) || (c >= 5'd10 && c <= 5'd13) || (c >= 5'd22);
  endfunction

  // Suppression scans from the most significant digit; digit 0 always shows
  function automatic logic [NUM_DIGITS-1:0] lz_of(input logic [NUM_DIGITS-1:0][4:0] c);
    logic lead;
    lz_of = '0;
    lead  = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      if (lead && zero_like(c[i])) lz_of[i] = 1'b1;
      else                         lead     = 1'b0;
    end
  endfunction

  always_ff @(posedge clk) begin
    if (reset)               lz <= '0;
    else if (wrap && pend_v) lz <= lz_of(pend_codes);
  end

  assign dark = act_blank[idx] | (act_blink[idx] & phase) | lz[idx];
`else
  assign dark = act_blank[idx] | (act_blink[idx] & phase);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      presc <= '0;
      idx   <= '0;
      fcnt  <= '0;
      phase <= 1'b0;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      if (tick) idx <= wrap ? '0 : idx + 1'b1;
      if (wrap) begin
        if (fcnt == FW'(BLINK_FRAMES - 1)) begin
          fcnt  <= '0;
          phase <= ~phase;
        end else begin
          fcnt  <= fcnt + 1'b1;
        end
      end
    end
  end

  // A load on the boundary cycle lands in pending while active takes the old pending
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_v     <= 1'b0;
      pend_codes <= {NUM_DIGITS{5'd31}};
      pend_blank <= '0;
      pend_blink <= '0;
      act_codes  <= {NUM_DIGITS{5'd31}};
      act_blank  <= '0;
      act_blink  <= '0;
    end else begin
      if (wrap && pend_v) begin
        act_codes <= pend_codes;
        act_blank <= pend_blank;
        act_blink <= pend_blink;
      end
      if (load) begin
        pend_codes <= codes;
        pend_blank <= blank_mask;
        pend_blink <= blink_mask;
        pend_v     <= 1'b1;
      end else if (wrap) begin
        pend_v     <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      seg <= 7'h7F;
      an  <= '1;
    end else begin
      seg <= dark ? 7'h7F : glyph(act_codes[idx]);
      an  <= ~(NUM_DIGITS'(1) << idx);
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Randomized bench for seven_seg_scan_driver against a cycle-count based display model.
module tb_seven_seg_scan_driver;
  localparam int N = 4, S = 4, BF = 2, FL = N * S;

  logic clk = 1'b0, reset = 1'b1, load = 1'b0;
  logic [5*N-1:0] codes = '0;
  logic [N-1:0] blank_mask = '0, blink_mask = '0;
  logic [6:0] seg;
  logic [N-1:0] an;

  seven_seg_scan_driver #(.NUM_DIGITS(N), .SCAN_DIV(S), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .reset(reset), .load(load), .codes(codes),
    .blank_mask(blank_mask), .blink_mask(blink_mask), .seg(seg), .an(an));

  always #5 clk = ~clk;

  typedef struct { int edge_n; logic [5*N-1:0] c; logic [N-1:0] bl; logic [N-1:0] bk; } ld_t;
  ld_t loads[$];
  int k = 0;
  int n_checks = 0, n_fail = 0;
  logic [6:0] es;
  logic [N-1:0] ea;

  function automatic string lit(input int code);
    case (code)
      0: return "abcdef";  1: return "bc";     2: return "abdeg";  3: return "abcdg";
      4: return "bcfg";    5: return "acdfg";  6: return "acdefg"; 7: return "abc";
      8: return "abcdefg"; 9: return "abcdfg"; 14: return "adefg"; 15: return "eg";
      16: return "acdfg";  17: return "cde";   18: return "cdefg"; 19: return "abefg";
      20: return "def";    21: return "bcdef";
      default: return "";
    endcase
  endfunction

  function automatic logic [6:0] seg_of(input int code);
    string s;
    logic [6:0] m;
    s = lit(code);
    m = 7'h7F;
    for (int i = 0; i < s.len(); i++) m[int'(s[i]) - 97] = 1'b0;
    return m;
  endfunction

  // Output after edge kk reflects the state after edge kk-1; edges counted from reset release
  function automatic void model(input int kk, output logic [6:0] eseg, output logic [N-1:0] ean);
    int j, idx, b, bnd, ph, code;
    logic [5*N-1:0] c;
    logic [N-1:0] bl, bk, lz;
    logic dark;
    bit lead;
    if (kk == 0) begin eseg = 7'h7F; ean = '1; return; end
    j = kk - 1; idx = (j / S) % N; b = j / FL; bnd = b * FL; ph = (b / BF) % 2;
    c = {N{5'd31}}; bl = '0; bk = '0; lz = '0;
    foreach (loads[q]) if (b > 0 && loads[q].edge_n < bnd) begin
      c = loads[q].c; bl = loads[q].bl; bk = loads[q].bk;
    end
`ifdef SEVSEG_LZ_BLANK_EN
    lead = 1'b1;
    for (int d = N - 1; d >= 1; d--) begin
      code = int'(c[5*d +: 5]);
      if (lead && (code == 0 || (code >= 10 && code <= 13) || code >= 22)) lz[d] = 1'b1;
      else lead = 1'b0;
    end
`endif
    code = int'(c[5*idx +: 5]);
    dark = bl[idx] | (bk[idx] & (ph == 1)) | lz[idx];
    eseg = dark ? 7'h7F : seg_of(code);
    ean  = ~(N'(1) << idx);
  endfunction

  task automatic step();
    @(posedge clk); #1;
    k++;
    load = 1'b0;
  endtask

  task automatic do_load(input logic [5*N-1:0] c, input logic [N-1:0] bl, input logic [N-1:0] bk);
    ld_t l;
    codes = c; blank_mask = bl; blink_mask = bk; load = 1'b1;
    l.edge_n = k + 1; l.c = c; l.bl = bl; l.bk = bk;
    loads.push_back(l);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0; k = 0; loads.delete();
    n_checks++;
    if (seg !== 7'h7F || an !== 4'hF) begin
      n_fail++; $display("FAIL reset_state seg=%h an=%b want seg=7f an=1111", seg, an);
    end
    step();
    n_checks++;
    if (seg !== 7'h7F || an !== 4'b1110) begin
      n_fail++; $display("FAIL first_slot seg=%h an=%b want seg=7f an=1110", seg, an);
    end
    repeat (FL - 1) begin
      step(); model(k, es, ea); n_checks++;
      if (seg !== es || an !== ea) begin
        n_fail++; $display("FAIL first_frame k=%0d seg=%h an=%b want seg=%h an=%b", k, seg, an, es, ea);
      end
    end
  endtask

  task automatic test_glyph_load();
    step(); step();
    do_load({5'd14, 5'd15, 5'd15, 5'd0}, '0, '0);
    repeat (2 * FL + 4) begin
      step(); model(k, es, ea); n_checks++;
      if (seg !== es || an !== ea) begin
        n_fail++; $display("FAIL glyph_load k=%0d seg=%h an=%b want seg=%h an=%b", k, seg, an, es, ea);
      end
    end
  endtask

  task automatic test_back_to_back();
    while (k % FL != 1) step();
    do_load({5'd1, 5'd2, 5'd3, 5'd4}, '0, '0);
    step(); step();
    do_load({5'd5, 5'd6, 5'd7, 5'd8}, '0, '0);
    repeat (2 * FL + 2) begin
      step(); model(k, es, ea); n_checks++;
      if (seg !== es || an !== ea) begin
        n_fail++; $display("FAIL back_to_back k=%0d seg=%h an=%b want seg=%h an=%b", k, seg, an, es, ea);
      end
    end
    while ((k + 1) % FL != 0) step();
    do_load({5'd21, 5'd20, 5'd19, 5'd18}, '0, '0);
    repeat (3 * FL) begin
      step(); model(k, es, ea); n_checks++;
      if (seg !== es || an !== ea) begin
        n_fail++; $display("FAIL boundary_load k=%0d seg=%h an=%b want seg=%h an=%b", k, seg, an, es, ea);
      end
    end
  endtask

  task automatic test_blink();
    do_load({4{5'd9}}, '0, 4'b0001);
    repeat (6 * FL) begin
      step(); model(k, es, ea); n_checks++;
      if (seg !== es || an !== ea) begin
        n_fail++; $display("FAIL blink k=%0d seg=%h an=%b want seg=%h an=%b", k, seg, an, es, ea);
      end
    end
  endtask

  task automatic test_lz();
    do_load({5'd0, 5'd0, 5'd7, 5'd0}, '0, '0);
    repeat (3 * FL) begin
      step(); model(k, es, ea); n_checks++;
      if (seg !== es || an !== ea) begin
        n_fail++; $display("FAIL lz k=%0d seg=%h an=%b want seg=%h an=%b", k, seg, an, es, ea);
      end
    end
  endtask

  task automatic test_reset_mid();
    while (k % FL != 5) step();
    do_load({5'd8, 5'd8, 5'd8, 5'd8}, '0, '0);
    step(); step();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; k = 0; loads.delete();
    n_checks++;
    if (seg !== 7'h7F || an !== 4'hF) begin
      n_fail++; $display("FAIL reset_mid seg=%h an=%b want seg=7f an=1111", seg, an);
    end
    repeat (3 * FL) begin
      step(); model(k, es, ea); n_checks++;
      if (seg !== es || an !== ea) begin
        n_fail++; $display("FAIL after_reset k=%0d seg=%h an=%b want seg=%h an=%b", k, seg, an, es, ea);
      end
    end
  endtask

  task automatic test_random();
    logic [5*N-1:0] rc;
    logic [N-1:0] rb, rk;
    repeat (30) begin
      repeat ($urandom_range(1, 12)) begin
        step(); model(k, es, ea); n_checks++;
        if (seg !== es || an !== ea) begin
          n_fail++; $display("FAIL random k=%0d seg=%h an=%b want seg=%h an=%b", k, seg, an, es, ea);
        end
      end
      rc = (5*N)'($urandom);
      rb = N'($urandom & $urandom);
      rk = N'($urandom);
      do_load(rc, rb, rk);
    end
    repeat (5 * FL) begin
      step(); model(k, es, ea); n_checks++;
      if (seg !== es || an !== ea) begin
        n_fail++; $display("FAIL random_tail k=%0d seg=%h an=%b want seg=%h an=%b", k, seg, an, es, ea);
      end
    end
  endtask

  initial begin
    test_reset();
    test_glyph_load();
    test_back_to_back();
    test_blink();
    test_lz();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
